// File: rtl/ub_reader_pkg.sv
// ub_reader_pkg: state encoding and default widths shared by the buffer reader.
package ub_reader_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/ub_reader_skid_fifo.sv
// ub_skid_fifo: two-entry FIFO that holds returned words while the sink stalls.
module ub_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic wp, rp;
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= !wp;
            end
            if (pop) rp <= !rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    assign dout = mem[rp];
    assign full = count == 2'd2;
    assign empty = count == 2'd0;
endmodule

// File: rtl/ub_reader.sv
// ub_reader: streams word_count buffer words from base_addr to a ready/valid sink.
// Define UB_READER_WRAP_EN to let addresses wrap instead of rejecting out-of-range starts.
module ub_reader
    import ub_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    state_t state;
    logic pend;
    logic [ADDR_W-1:0] rd_left, words_left;
    logic [DATA_W-1:0] head;
    logic full, empty;
    logic [1:0] count;
    logic push, pop, hs, issue, too_far;
    logic [2:0] occ;

    ub_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(mem_rd_data),
        .dout(head), .full(full), .empty(empty), .count(count)
    );

    // Returning data bypasses the FIFO when it is empty, giving first word at start+2.
    assign out_valid = !empty || pend;
    assign out_data = !empty ? head : pend ? mem_rd_data : '0;
    assign hs = out_valid && out_ready;
    assign pop = !empty && out_ready;
    assign push = pend && !(empty && out_ready) && (!full || pop);
    assign occ = {1'b0, count + {1'b0, push} - {1'b0, pop}} + {2'b0, mem_rd_en};
    assign issue = rd_left != '0 && occ < 3'd2;
`ifdef UB_READER_WRAP_EN
    assign too_far = 1'b0;
`else
    assign too_far = ({1'b0, base_addr} + {1'b0, word_count}) > {1'b1, {ADDR_W{1'b0}}};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_rd_addr <= '0;
            pend <= 1'b0;
            rd_left <= '0;
            words_left <= '0;
        end else begin
            pend <= mem_rd_en;
            done <= 1'b0;
            err <= 1'b0;
            if (hs) words_left <= words_left - 1'b1;
            case (state)
                IDLE: if (start) begin
                    if (too_far) err <= 1'b1;
                    else if (word_count == '0) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else begin
                        state <= READ;
                        busy <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_rd_addr <= base_addr;
                        rd_left <= word_count - 1'b1;
                        words_left <= word_count;
                    end
                end
                READ: begin
                    mem_rd_en <= issue;
                    if (issue) begin
                        mem_rd_addr <= mem_rd_addr + 1'b1;
                        rd_left <= rd_left - 1'b1;
                    end
                    if (rd_left == '0) state <= DRAIN;
                end
                DRAIN: if (hs && words_left == ADDR_W'(1)) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ub_reader.sv
// tb_ub_reader: directed bench for ub_reader with address/data scoreboards.
module tb_ub_reader;
    logic clk = 0, reset, start, out_ready;
    logic [7:0] base_addr, word_count, mem_rd_addr;
    logic busy, done, err, mem_rd_en, out_valid;
    logic [31:0] mem_rd_data = 0, out_data;
    logic [7:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int checks = 0, passed = 0, issued = 0, taken = 0, done_cnt = 0, err_cnt = 0;
    logic prev_stall = 0;
    logic [31:0] prev_data = 0;

    ub_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = !clk;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= 32'(mem_rd_addr) * 3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_rd_en) begin
                issued++;
                check("read_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check("rd_addr", mem_rd_addr, exp_addr.pop_front());
            end
            if (out_valid && out_ready) begin
                taken++;
                check("word_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) check("out_data", out_data, exp_data.pop_front());
            end
            if (mem_rd_en) check("max_outstanding", (issued - taken) <= 2, 1);
            if (prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            done_cnt += int'(done);
            err_cnt += int'(err);
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end else prev_stall = 0;
    end

    task automatic go(input logic [7:0] b, input logic [7:0] n, input bit accept);
        @(posedge clk); #1;
        start = 1; base_addr = b; word_count = n;
        if (accept) for (int i = 0; i < int'(n); i++) begin
            logic [7:0] a;
            a = b + 8'(i);
            exp_addr.push_back(a);
            exp_data.push_back(32'(a) * 3);
        end
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < lim);
        check(tag, done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, d0, i0, e0;
        reset = 0; start = 0; base_addr = 0; word_count = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", mem_rd_addr, 0);
        check("rst_data", out_data, 0);
        @(posedge clk); #1 reset = 1;

        go(8'h10, 8'd4, 1);
        @(negedge clk);
        check("s_rd_en_n1", mem_rd_en, 1);
        check("s_valid_n1", out_valid, 0);
        check("s_busy_n1", busy, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s_valid", out_valid, 1);
            check("s_data", out_data, 32'h30 + 32'(3 * i));
        end
        @(negedge clk);
        check("s_done_n6", done, 1);
        @(negedge clk);
        check("s_done_once", done, 0);
        check("s_busy_after", busy, 0);
        check("s_drained", exp_data.size(), 0);

        t0 = taken;
        go(8'h60, 8'd6, 1);
        for (int c = 0; c < 80; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
        end
        check("bp_done", done, 1);
        out_ready = 1;
        check("bp_count", taken - t0, 6);
        check("bp_drained", exp_data.size(), 0);

        i0 = issued; d0 = done_cnt;
        go(8'h55, 8'd0, 1);
        @(negedge clk);
        check("z_done_n1", done, 1);
        check("z_busy_n1", busy, 0);
        check("z_rd_en_n1", mem_rd_en, 0);
        @(negedge clk);
        check("z_done_once", done, 0);
        check("z_busy_n2", busy, 0);
        check("z_no_reads", issued - i0, 0);

        go(8'hFC, 8'd4, 1);
        wait_done("edge_fit_done", 20);
        check("edge_fit_drained", exp_data.size(), 0);

        e0 = err_cnt; i0 = issued;
`ifdef UB_READER_WRAP_EN
        go(8'hFE, 8'd4, 1);
        wait_done("wrap_done", 20);
        check("wrap_drained", exp_addr.size() + exp_data.size(), 0);
        check("wrap_no_err", err_cnt - e0, 0);
`else
        go(8'hFE, 8'd4, 0);
        @(negedge clk);
        check("b_err_n1", err, 1);
        check("b_rd_en_n1", mem_rd_en, 0);
        check("b_busy_n1", busy, 0);
        @(negedge clk);
        check("b_err_once", err, 0);
        check("b_idle", {busy, mem_rd_en, done}, 0);
        check("b_no_reads", issued - i0, 0);
`endif

        t0 = taken; d0 = done_cnt; e0 = err_cnt;
        go(8'h20, 8'd5, 1);
        @(posedge clk); #1;
        start = 1; base_addr = 8'h80; word_count = 8'd3;
        @(posedge clk); #1;
        start = 0;
        wait_done("dbl_done", 30);
        repeat (4) @(negedge clk);
        check("dbl_count", taken - t0, 5);
        check("dbl_one_done", done_cnt - d0, 1);
        check("dbl_no_err", err_cnt - e0, 0);

        t0 = taken;
        go(8'h30, 8'd8, 1);
        for (int k = 0; k < 20 && taken - t0 < 2; k++) @(negedge clk);
        check("r_two_taken", taken - t0 >= 2, 1);
        @(posedge clk); #1 reset = 0;
        @(posedge clk);
        @(negedge clk);
        check("r_valid", out_valid, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        check("r_rd_en", mem_rd_en, 0);
        exp_addr.delete();
        exp_data.delete();
        issued = 0; taken = 0; d0 = done_cnt;
        @(posedge clk); #1 reset = 1;
        repeat (4) @(negedge clk);
        check("r_no_done", done_cnt - d0, 0);
        go(8'h40, 8'd3, 1);
        wait_done("r_fresh_done", 20);
        check("r_fresh_count", taken, 3);
        check("r_fresh_drained", exp_data.size(), 0);

        repeat (2) @(negedge clk);
`ifdef UB_READER_WRAP_EN
        check("err_total", err_cnt, 0);
`else
        check("err_total", err_cnt, 1);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ub_reader.md
UB_READER -- requirements
Module: ub_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, buffer address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port base_addr  input  ADDR_W  first buffer address, sampled on accepted start.
REQ-007 SHALL have port word_count  input  ADDR_W  number of words, sampled on accepted start; 0 is legal.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-011 SHALL have port mem_rd_en  output  1  buffer read strobe.
REQ-012 SHALL have port mem_rd_addr  output  ADDR_W  buffer read address.
REQ-013 SHALL have port mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 SHALL have port out_data  output  DATA_W  streamed word.
REQ-015 SHALL have port out_valid  output  1  out_data valid.
REQ-016 SHALL have port out_ready  input  1  sink accepts; transfer when out_valid && out_ready.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, DONE: IDLE->READ on accepted start with word_count>0; IDLE->DONE on accepted start with word_count==0; READ->DRAIN after the last read issues; DRAIN->DONE on the last output handshake; DONE->IDLE unconditionally.
REQ-018 SHALL accept start only in IDLE; start in any other state SHALL be ignored, with no err.
REQ-019 SHALL issue reads at consecutive addresses base_addr, base_addr+1, ..., one per cycle at most.
REQ-020 SHALL buffer returned words in a 2-entry FIFO and SHALL issue a read only when buffered plus in-flight words < 2, so no word is ever dropped.
REQ-021 SHALL present the FIFO head on out_data and hold it stable while out_valid && !out_ready.
REQ-022 SHALL give latency: start at cycle N -> mem_rd_en at N+1 -> first out_valid at N+2.
REQ-023 SHALL sustain 1 word/cycle while out_ready stays high.
REQ-024 SHALL assert done exactly one cycle, in DONE, the cycle after the final handshake, or the cycle after start when word_count==0.
REQ-025 SHALL count words exactly; the total number of handshakes SHALL equal word_count.

Reset
REQ-026 SHALL, on reset==0 at posedge clk, set state IDLE; busy, done, err, mem_rd_en and out_valid 0; mem_rd_addr and out_data 0; FIFO empty.
REQ-027 SHALL treat reset mid-transfer as an abort: in-flight and buffered words are discarded, and no done is produced.

Configuration
REQ-028 SHALL use macro UB_READER_WRAP_EN: when defined, addresses wrap modulo 2^ADDR_W (255 -> 0) and err stays 0.
REQ-029 SHALL, when UB_READER_WRAP_EN is undefined, reject a start with base_addr+word_count > 2^ADDR_W: err pulses the next cycle, no reads issue, and the FSM stays in IDLE.

Structure
REQ-030 SHALL define the state_t enum (2-bit: IDLE, READ, DRAIN, DONE) and the ADDR_W/DATA_W defaults in package ub_reader_pkg.
REQ-031 SHALL place the 2-entry buffer in sub-module ub_skid_fifo (push/pop/full/empty/count).

Verification
REQ-032 SHALL cover streaming: base=0x10, count=4, out_ready=1, mem returns addr*3 -> out_data 0x30,0x33,0x36,0x39 on cycles N+2..N+5; done at N+6.
REQ-033 SHALL cover backpressure: count=6, out_ready toggles 1,0,0,1,... -> words unchanged while stalled, no loss or duplication, at most 2 reads outstanding.
REQ-034 SHALL cover zero count: start with count=0 -> no mem_rd_en, done at N+1, busy low throughout.
REQ-035 SHALL cover the boundary: base=0xFE, count=4 -> with macro, addresses FE,FF,00,01; without it, err at N+1 and no reads.
REQ-036 SHALL cover start during a transfer: a second start while busy -> ignored; only the original count of words is streamed.
REQ-037 SHALL cover reset mid-transfer: reset=0 after 2 of 8 words -> next cycle out_valid=0, busy=0, no done; a fresh start then runs normally.
